fft256_stg2_bf2_twiddle: RTL

- Second half of the first radix-2^2 SDF stage of the 256-point FFT.
- Consumes the 256-sample stream from FFT256Stg1 (BF2I with 128-deep feedback and -j rotation).
- Performs the BF2II butterfly using a 64-deep feedback delay, then multiplies each sample by the inter-stage twiddle W256^e.
- Feeds the next 64-point SDF stage. The twiddle ROM is external and has registered read.

---
 rtl/fft256_stg2_bf2_twiddle.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fft256_stg2_bf2_twiddle.sv
// ---------------------------------------------------------------------------
// fft256_stg2_bf2_twiddle
//
// Second half of the first radix-2^2 SDF stage of the 256-point FFT. This
// block takes the BF2I output stream and applies the BF2II butterfly through
// a 64-deep feedback delay. It then multiplies every sample by the
// inter-stage twiddle W256^e, using an external twiddle ROM with a registered
// read. The result feeds the next 64-point SDF stage.
//
// Ports
//   clock            master clock
//   reset            asynchronous active-high reset
//   di_en            input enable, 256 contiguous cycles per frame
//   di_re / di_im    input sample (signed WIDTH)
//   tw_addr          twiddle ROM address (exponent e, 0..189)
//   tw_re / tw_im    ROM data, valid one cycle after tw_addr
//   do_en            output enable, 256 contiguous cycles per frame
//   do_re / do_im    output sample (signed WIDTH), don't-care when do_en=0
//
// Latency: sample 0 in cycle 0 -> output m in cycle 67+m.
// ---------------------------------------------------------------------------
module fft256_stg2_bf2_twiddle #(
    parameter int WIDTH    = 16,
    parameter int TW_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       di_en,
    input  logic signed [WIDTH-1:0]    di_re,
    input  logic signed [WIDTH-1:0]    di_im,
    output logic [7:0]                 tw_addr,
    input  logic signed [TW_WIDTH-1:0] tw_re,
    input  logic signed [TW_WIDTH-1:0] tw_im,
    output logic                       do_en,
    output logic signed [WIDTH-1:0]    do_re,
    output logic signed [WIDTH-1:0]    do_im
);

    localparam int PW = WIDTH + TW_WIDTH;   // full product width
    localparam int SW = PW + 1;             // sum of two products
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (TW_WIDTH - 2);

    // control
    logic [7:0] r_di_count;
    logic       r_sp_en;
    logic [7:0] r_sp_count;
    logic       w_sp_en_nxt;
    logic [7:0] w_sp_count_nxt;
    logic [7:0] w_e;
    logic [7:0] w_n8;
    logic       r_bf_en;
    logic       r_prod_en;
    logic       r_byp;

    // butterfly / delay line
    logic signed [WIDTH-1:0] r_db_re [0:63];
    logic signed [WIDTH-1:0] r_db_im [0:63];
    logic                    w_bf;
    logic signed [WIDTH-1:0] w_db_out_re, w_db_out_im;
    logic signed [WIDTH-1:0] w_db_in_re,  w_db_in_im;
    logic signed [WIDTH-1:0] w_sp_re,     w_sp_im;
    logic signed [WIDTH-1:0] r_bf_re,     r_bf_im;

    // multiplier
    logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [SW-1:0] w_sum_re, w_sum_im;
    logic signed [SW-1:0] w_shr_re, w_shr_im;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v[SW-1:WIDTH-1] == {(SW-WIDTH+1){v[SW-1]}})
            return v[WIDTH-1:0];
        else if (v[SW-1])
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // ------------------------------------------------------------------
    // Sequencing. If the set and the clear happen together, the set wins,
    // so back-to-back frames keep sp_en high and sp_count wraps to 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_sp_en_nxt = r_sp_en;
        if (r_di_count == 8'd63)
            w_sp_en_nxt = 1'b1;
        else if (r_sp_count == 8'd255)
            w_sp_en_nxt = 1'b0;
        w_sp_count_nxt = r_sp_en ? r_sp_count + 8'd1 : r_sp_count;
    end

    // e = n*k with k = 0,2,1,3 for quadrant 0..3; max 63*3 = 189
    always_comb begin
        w_n8 = {2'b00, w_sp_count_nxt[5:0]};
        w_e  = 8'd0;
        case (w_sp_count_nxt[7:6])
            2'd0: w_e = 8'd0;
            2'd1: w_e = w_n8 << 1;
            2'd2: w_e = w_n8;
            2'd3: w_e = (w_n8 << 1) + w_n8;
            default: w_e = 8'd0;
        endcase
    end

    // tw_addr is loaded from the exponent of the sample that becomes current
    // in the next cycle. This makes tw_addr equal e(sp_count) while that sample
    // is being registered. The ROM's registered read then delivers the
    // twiddle in the same cycle that r_bf holds the sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_di_count <= 8'd0;
            r_sp_en    <= 1'b0;
            r_sp_count <= 8'd0;
            tw_addr    <= 8'd0;
            r_bf_en    <= 1'b0;
            r_byp      <= 1'b0;
            r_prod_en  <= 1'b0;
            do_en      <= 1'b0;
        end else begin
            r_di_count <= di_en ? r_di_count + 8'd1 : 8'd0;
            r_sp_en    <= w_sp_en_nxt;
            r_sp_count <= w_sp_count_nxt;
            tw_addr    <= w_e;
            r_bf_en    <= r_sp_en;
            r_byp      <= (tw_addr == 8'd0);
            r_prod_en  <= r_bf_en;
            do_en      <= r_prod_en;
        end
    end

    // ------------------------------------------------------------------
    // BF2II butterfly with 64-deep feedback delay (no -j rotation here)
    // ------------------------------------------------------------------
    assign w_bf        = r_di_count[6];
    assign w_db_out_re = r_db_re[63];
    assign w_db_out_im = r_db_im[63];

    always_comb begin
        if (w_bf) begin
            w_sp_re    = w_db_out_re + di_re;
            w_sp_im    = w_db_out_im + di_im;
            w_db_in_re = w_db_out_re - di_re;
            w_db_in_im = w_db_out_im - di_im;
        end else begin
            w_sp_re    = w_db_out_re;
            w_sp_im    = w_db_out_im;
            w_db_in_re = di_re;
            w_db_in_im = di_im;
        end
    end

    always_ff @(posedge clock) begin
        r_db_re[0] <= w_db_in_re;
        r_db_im[0] <= w_db_in_im;
        for (int k = 1; k < 64; k++) begin
            r_db_re[k] <= r_db_re[k-1];
            r_db_im[k] <= r_db_im[k-1];
        end
        r_bf_re <= w_sp_re;
        r_bf_im <= w_sp_im;
    end

    // ------------------------------------------------------------------
    // Complex multiply. For e=0 the ROM is ignored, and the data is scaled
    // by exactly 2^(TW_WIDTH-1). That value cannot be represented in the
    // twiddle format, but it makes the round and shift return the input
    // unchanged.
    // ------------------------------------------------------------------
    always_comb begin
        if (r_byp) begin
            w_p_rr = PW'(r_bf_re) <<< (TW_WIDTH - 1);
            w_p_ii = '0;
            w_p_ri = '0;
            w_p_ir = PW'(r_bf_im) <<< (TW_WIDTH - 1);
        end else begin
            w_p_rr = PW'(r_bf_re) * PW'(tw_re);
            w_p_ii = PW'(r_bf_im) * PW'(tw_im);
            w_p_ri = PW'(r_bf_re) * PW'(tw_im);
            w_p_ir = PW'(r_bf_im) * PW'(tw_re);
        end
    end

    assign w_sum_re = SW'(r_p_rr) - SW'(r_p_ii);
    assign w_sum_im = SW'(r_p_ri) + SW'(r_p_ir);
    assign w_shr_re = (w_sum_re + RND) >>> (TW_WIDTH - 1);
    assign w_shr_im = (w_sum_im + RND) >>> (TW_WIDTH - 1);

    always_ff @(posedge clock) begin
        r_p_rr <= w_p_rr;
        r_p_ii <= w_p_ii;
        r_p_ri <= w_p_ri;
        r_p_ir <= w_p_ir;
        do_re  <= sat(w_shr_re);
        do_im  <= sat(w_shr_im);
    end

endmodule
